// File: rtl/serial_sub_unit.sv
// Digit-serial subtractor: A - B computed DIGIT bits per clock as A + ~B + 1 with a rippled carry.
// Define SUB_CMP_FLAGS_EN to add the isNotEqual / isLessThan ports and registers.

module serial_sub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] nb,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
);
    logic [DIGIT:0] sum;

    always_comb begin
        sum = {1'b0, a} + {1'b0, nb} + {{DIGIT{1'b0}}, cin};
    end

    assign s    = sum[DIGIT-1:0];
    assign cout = sum[DIGIT];
endmodule

module serial_sub_unit #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_result,
    output logic             overflow,
    output logic             borrow
`ifdef SUB_CMP_FLAGS_EN
    ,
    output logic             isNotEqual,
    output logic             isLessThan
`endif
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] nb_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_next;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             a_sign_q;
    logic             b_sign_q;

    logic [DIGIT-1:0] digit_s;
    logic             digit_c;
    logic             accept;
    logic             last_step;
    logic             ovf_next;

    assign accept    = in_valid & in_ready;
    assign last_step = (state_q == S_RUN) && (cnt_q == CNT_W'(STEPS - 1));

    serial_sub_digit #(.DIGIT(DIGIT)) u_digit (
        .a    (a_q[DIGIT-1:0]),
        .nb   (nb_q[DIGIT-1:0]),
        .cin  (carry_q),
        .s    (digit_s),
        .cout (digit_c)
    );

    // New digit enters at the top; after STEPS shifts digit 0 sits at the bottom.
    generate
        if (STEPS == 1) begin : g_one
            assign res_next = digit_s;
        end else begin : g_multi
            assign res_next = {digit_s, res_q[WIDTH-1:DIGIT]};
        end
    endgenerate

    // Signs come from the latched operands; the shifting copies lose them.
    assign ovf_next = (a_sign_q != b_sign_q) & (res_next[WIDTH-1] != a_sign_q);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_RUN;
            S_RUN:   if (last_step) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE:  in_ready  = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // ---------------- serial datapath ----------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            a_q      <= '0;
            nb_q     <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_sign_q <= 1'b0;
            b_sign_q <= 1'b0;
        end else if (accept) begin
            a_q      <= data_operandA;
            nb_q     <= ~data_operandB;
            cnt_q    <= '0;
            carry_q  <= 1'b1;
            a_sign_q <= data_operandA[WIDTH-1];
            b_sign_q <= data_operandB[WIDTH-1];
        end else if (state_q == S_RUN) begin
            a_q     <= a_q >> DIGIT;
            nb_q    <= nb_q >> DIGIT;
            res_q   <= res_next;
            carry_q <= digit_c;
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

    // ---------------- result registers, loaded only on DONE entry ----------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            data_result <= '0;
            overflow    <= 1'b0;
            borrow      <= 1'b0;
        end else if (last_step) begin
            data_result <= res_next;
            overflow    <= ovf_next;
            borrow      <= ~digit_c;
        end
    end

`ifdef SUB_CMP_FLAGS_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            isNotEqual <= 1'b0;
            isLessThan <= 1'b0;
        end else if (last_step) begin
            isNotEqual <= |res_next;
            isLessThan <= res_next[WIDTH-1] ^ ovf_next;
        end
    end
`endif

endmodule

// File: doc/serial_sub_unit.md
# serial_sub_unit

Multi-cycle 32-bit subtractor for the SimpleALU datapath. It computes `data_operandA - data_operandB` one DIGIT-wide slice per clock, using a valid/ready handshake on both its input and output sides. It reports signed overflow and unsigned borrow, and optionally comparison flags. It is the subtract counterpart of the combinational add path: same operand and result naming, same overflow semantics, but a sequenced ripple-borrow rather than a single-cycle carry chain.

## Interface
- `WIDTH`, default 32: operand and result width.
- `DIGIT`, default 4: bits processed per cycle. `WIDTH % DIGIT == 0` is required. `STEPS = WIDTH/DIGIT`, which is 8 at the defaults.

- `clock`  in  1: single clock; all state updates on the rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: operands are presented.
- `in_ready`  out  1: the unit can accept operands. High only in IDLE.
- `data_operandA`  in  WIDTH: minuend.
- `data_operandB`  in  WIDTH: subtrahend.
- `out_valid`  out  1: result registers hold a completed result.
- `out_ready`  in  1: consumer takes the result.
- `data_result`  out  WIDTH: A − B, modulo 2^WIDTH.
- `overflow`  out  1: signed two's-complement overflow.
- `borrow`  out  1: unsigned A < B.
- `isNotEqual`  out  1: present only with `SUB_CMP_FLAGS_EN`.
- `isLessThan`  out  1: present only with `SUB_CMP_FLAGS_EN`.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE**
  - `in_ready = 1`.
  - On `in_valid & in_ready`:
    - latch A into `a_q` and `~B` into `nb_q`;
    - set `carry_q = 1`;
    - clear step counter `cnt`;
    - go to RUN.
  - Operand inputs are ignored at all other times.
- **RUN**
  - Each cycle computes `{c, s} = a_q[DIGIT-1:0] + nb_q[DIGIT-1:0] + carry_q`.
  - `s` is shifted into the top of the result shift register.
  - `a_q` and `nb_q` shift right by DIGIT.
  - `carry_q = c` and `cnt++`.
  - When `cnt == STEPS-1` on that edge, go to DONE and load the output registers.
- **DONE**
  - `out_valid = 1`.
  - `data_result` and all flags stay stable until `out_valid & out_ready`, then go to IDLE.
- Flag rules, evaluated at DONE entry with R = result and `cout` = final carry:
  - `overflow = (A[MSB] != B[MSB]) & (R[MSB] != A[MSB])`, using the latched A and B sign bits;
  - `borrow = ~cout`;
  - `isNotEqual = |R`;
  - `isLessThan = R[MSB] ^ overflow` (signed A < B).
- Output registers keep the last result while in IDLE and RUN. They change only at DONE entry.

## Timing
- Reset (`resetn` low, asynchronous):
  - state = IDLE;
  - `in_ready = 1`;
  - `out_valid = 0`;
  - `data_result = 0`;
  - `overflow = borrow = isNotEqual = isLessThan = 0`;
  - internal shift registers, counter and carry cleared.
- Latency:
  - Accept occurs at edge E0.
  - RUN occupies edges E1..E_STEPS.
  - `out_valid` is high after E_STEPS (E8 at defaults).
  - So the result is visible 8 cycles after acceptance.
- Throughput:
  - With `out_ready` held high, DONE lasts one cycle and IDLE one cycle.
  - Best case is one operation per STEPS+2 = 10 cycles.
- Backpressure: DONE holds indefinitely while `out_ready = 0`. `in_ready` stays 0 and `in_valid` is ignored.
- `in_valid` asserted during RUN or DONE is neither accepted nor queued.
- Reset asserted mid-RUN or in DONE:
  - the operation is abandoned;
  - all outputs return to reset values immediately, without waiting for a clock;
  - the first accept after reset release produces a correct result.
- `out_ready` high before DONE has no effect.

## Configuration
- `SUB_CMP_FLAGS_EN` defined:
  - the `isNotEqual` and `isLessThan` ports and their registers exist;
  - they are updated at DONE entry per the flag rules.
- Not defined: both ports and registers are absent, and every other behaviour is unchanged.

## Test plan
- **Basic subtract:** after reset, A=5, B=3 → `data_result=0x00000002`, `overflow=0`, `borrow=0`, `isNotEqual=1`, `isLessThan=0`. `out_valid` rises exactly 8 cycles after accept.
- **Underflow:** A=0, B=1 → `0xFFFFFFFF`, `borrow=1`, `overflow=0`, `isLessThan=1`.
- **Signed overflow:** A=0x80000000, B=1 → `0x7FFFFFFF`, `overflow=1`, `borrow=0`, `isLessThan=1`. Also A=0x7FFFFFFF, B=0xFFFFFFFF → `0x80000000`, `overflow=1`, `borrow=1`.
- **Walking equality:** for i=0..31, A=B=1<<i → `data_result=0`, `isNotEqual=0`, `borrow=0`, `overflow=0`. Checked on every handshake.
- **Backpressure:**
  - Hold `out_ready=0` for 5 cycles in DONE while toggling `in_valid` with new operands.
  - Result and flags must stay constant and `in_ready=0`.
  - No extra result appears after `out_ready` rises.
- **Reset mid-operation:**
  - Drop `resetn` at cycle 4 of RUN (A=10, B=4).
  - Outputs must be 0 and `in_ready=1` with no clock edge.
  - After release, A=10, B=4 → `0x00000006`.
